// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: controller state/cycle codes, the
// 7-segment hex decode and the front-panel beep FSM types.
package wm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FILL     = 3'b001,
    WASH     = 3'b010,
    RINSE    = 3'b011,
    SPIN     = 3'b100,
    DRAIN    = 3'b101,
    PAUSED   = 3'b110,
    COMPLETE = 3'b111
  } wm_state_e;

  typedef enum logic [1:0] {
    DELICATE = 2'b00,
    NORMAL   = 2'b01,
    HEAVY    = 2'b10
  } wm_cycle_e;

  typedef enum logic [1:0] {
    B_IDLE = 2'b00,
    B_ON   = 2'b01,
    B_OFF  = 2'b10,
    B_DONE = 2'b11
  } beep_state_e;

  typedef enum logic {
    MODE_REPEAT  = 1'b0,
    MODE_ONESHOT = 1'b1
  } beep_mode_e;

  // Active-high segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/wm_debounce.sv
// Two-flop synchronizer, counting debouncer and registered rising-edge pulse
// for one asynchronous panel input.
module wm_debounce
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = sync_q;
        rise_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  assign level_o = db_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/wm_front_panel.sv
// Operator front panel: conditions buttons/door switch for the controller and
// drives the 7-segment digits, cycle/lock LEDs and the patterned buzzer.
module wm_front_panel
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BEEP_ON         = 8,
  parameter int BEEP_OFF        = 8,
  parameter int BEEP_COUNT      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_cycle_raw,
  input  logic       door_sw_raw,
  output logic       start_stop,
  output logic       cycle_select,
  output logic       door_open,
  input  logic [2:0] led_state,
  input  logic [1:0] led_cycle,
  input  logic       door_lock,
  input  logic       buzzer,
  input  logic [3:0] timer_display,
  output logic [6:0] seg_timer,
  output logic [6:0] seg_state,
  output logic [2:0] cycle_leds,
  output logic       lock_led,
  output logic       buzzer_out
);

  localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BC_W   = $clog2(BEEP_COUNT + 1);

  logic start_level, start_rise, cycle_level, cycle_rise, door_rise;
  logic unused_ok;

  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .raw_i(btn_start_raw), .level_o(start_level), .rise_o(start_rise)
  );
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cycle (
    .clk(clk), .reset(reset), .raw_i(btn_cycle_raw), .level_o(cycle_level), .rise_o(cycle_rise)
  );
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_door (
    .clk(clk), .reset(reset), .raw_i(door_sw_raw), .level_o(door_open), .rise_o(door_rise)
  );

  assign unused_ok    = ^{start_level, cycle_level, door_rise};
  assign start_stop   = start_rise;
  // Cycle changes are only meaningful to the controller while it is idle.
  assign cycle_select = cycle_rise && (led_state == IDLE);

  logic [6:0] seg_timer_q, seg_state_q;
  logic [2:0] cycle_leds_q, cycle_leds_d;
  logic       lock_led_q;

  always_comb begin
    case (led_cycle)
      DELICATE: cycle_leds_d = 3'b001;
      NORMAL:   cycle_leds_d = 3'b010;
      HEAVY:    cycle_leds_d = 3'b100;
      default:  cycle_leds_d = 3'b000;
    endcase
  end

  beep_state_e      bstate_q, bstate_d;
  beep_mode_e       mode_q, mode_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [BC_W-1:0]  beeps_q, beeps_d;
  logic             buzzer_prev_q;
  logic             buzzer_out_q;

  always_comb begin
    bstate_d = bstate_q;
    mode_d   = mode_q;
    phase_d  = phase_q;
    beeps_d  = beeps_q;
    if (!buzzer) begin
      bstate_d = B_IDLE;
    end else begin
      unique case (bstate_q)
        B_IDLE: begin
          if (!buzzer_prev_q) begin
            bstate_d = B_ON;
            phase_d  = '0;
            beeps_d  = '0;
            mode_d   = (led_state == COMPLETE) ? MODE_ONESHOT : MODE_REPEAT;
          end
        end
        B_ON: begin
          if (phase_q == PH_W'(BEEP_ON - 1)) begin
            bstate_d = B_OFF;
            phase_d  = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        B_OFF: begin
          if (phase_q == PH_W'(BEEP_OFF - 1)) begin
            phase_d = '0;
            if (mode_q == MODE_ONESHOT && beeps_q == BC_W'(BEEP_COUNT - 1)) begin
              bstate_d = B_DONE;
            end else begin
              bstate_d = B_ON;
              if (mode_q == MODE_ONESHOT) beeps_d = beeps_q + 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        B_DONE:  bstate_d = B_DONE;
        default: bstate_d = B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_timer_q   <= '0;
      seg_state_q   <= '0;
      cycle_leds_q  <= '0;
      lock_led_q    <= 1'b0;
      bstate_q      <= B_IDLE;
      mode_q        <= MODE_REPEAT;
      phase_q       <= '0;
      beeps_q       <= '0;
      buzzer_prev_q <= 1'b0;
      buzzer_out_q  <= 1'b0;
    end else begin
      seg_timer_q   <= hex7(timer_display);
      seg_state_q   <= hex7({1'b0, led_state});
      cycle_leds_q  <= cycle_leds_d;
      lock_led_q    <= door_lock;
      bstate_q      <= bstate_d;
      mode_q        <= mode_d;
      phase_q       <= phase_d;
      beeps_q       <= beeps_d;
      buzzer_prev_q <= buzzer;
      buzzer_out_q  <= (bstate_d == B_ON);
    end
  end

  assign seg_timer  = seg_timer_q;
  assign seg_state  = seg_state_q;
  assign cycle_leds = cycle_leds_q;
  assign lock_led   = lock_led_q;
  assign buzzer_out = buzzer_out_q;

endmodule

// File: tb/tb_wm_front_panel.sv
// Directed bench for wm_front_panel with short debounce and beep timings.
module tb_wm_front_panel;

  logic       clk;
  logic       reset;
  logic       btn_start_raw, btn_cycle_raw, door_sw_raw;
  logic       start_stop, cycle_select, door_open;
  logic [2:0] led_state;
  logic [1:0] led_cycle;
  logic       door_lock, buzzer;
  logic [3:0] timer_display;
  logic [6:0] seg_timer, seg_state;
  logic [2:0] cycle_leds;
  logic       lock_led, buzzer_out;

  int n_checks = 0;
  int n_fail   = 0;

  wm_front_panel #(
    .DEBOUNCE_CYCLES(4), .BEEP_ON(2), .BEEP_OFF(2), .BEEP_COUNT(3)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_start_raw(btn_start_raw), .btn_cycle_raw(btn_cycle_raw), .door_sw_raw(door_sw_raw),
    .start_stop(start_stop), .cycle_select(cycle_select), .door_open(door_open),
    .led_state(led_state), .led_cycle(led_cycle), .door_lock(door_lock), .buzzer(buzzer),
    .timer_display(timer_display), .seg_timer(seg_timer), .seg_state(seg_state),
    .cycle_leds(cycle_leds), .lock_led(lock_led), .buzzer_out(buzzer_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_start_raw = 1'b0; btn_cycle_raw = 1'b0; door_sw_raw = 1'b0;
    led_state = 3'b111; led_cycle = 2'b01; door_lock = 1'b1; buzzer = 1'b1;
    timer_display = 4'h5;
    ticks(3);
    if ({start_stop, cycle_select, door_open} !== 3'b000) begin
      $display("FAIL reset_pulses: got %b expected 000", {start_stop, cycle_select, door_open});
      n_fail++;
    end
    n_checks++;
    if ({seg_timer, seg_state} !== 14'h0) begin
      $display("FAIL reset_segs: got %h/%h expected 00/00", seg_timer, seg_state);
      n_fail++;
    end
    n_checks++;
    if ({cycle_leds, lock_led, buzzer_out} !== 5'b0) begin
      $display("FAIL reset_leds: got %b expected 00000", {cycle_leds, lock_led, buzzer_out});
      n_fail++;
    end
    n_checks++;
    led_state = 3'b000; led_cycle = 2'b00; door_lock = 1'b0; buzzer = 1'b0;
    timer_display = 4'h0;
    reset = 1'b0;
    tick();
    if ({seg_timer, seg_state, cycle_leds} !== {7'h3F, 7'h3F, 3'b001}) begin
      $display("FAIL post_reset_display: got %h %h %b expected 3f 3f 001", seg_timer, seg_state, cycle_leds);
      n_fail++;
    end
    n_checks++;
    ticks(4);
  endtask

  task automatic test_door();
    bit seen;
    door_sw_raw = 1'b1;
    ticks(5);
    if (door_open !== 1'b0) begin
      $display("FAIL door_edge5: got %b expected 0", door_open);
      n_fail++;
    end
    n_checks++;
    tick();
    if (door_open !== 1'b1) begin
      $display("FAIL door_edge6: got %b expected 1", door_open);
      n_fail++;
    end
    n_checks++;
    door_sw_raw = 1'b0;
    ticks(6);
    if (door_open !== 1'b0) begin
      $display("FAIL door_release: got %b expected 0", door_open);
      n_fail++;
    end
    n_checks++;
    ticks(3);
    door_sw_raw = 1'b1;
    ticks(3);
    door_sw_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (door_open) seen = 1'b1;
    end
    if (seen !== 1'b0) begin
      $display("FAIL door_glitch: got high=%b expected 0", seen);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_start();
    bit seen;
    led_state = 3'b000;
    btn_start_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (start_stop !== (i == 6)) begin
        $display("FAIL start_hold[%0d]: got %b expected %b", i, start_stop, (i == 6));
        n_fail++;
      end
      n_checks++;
    end
    btn_start_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start_stop || cycle_select) seen = 1'b1;
    end
    if (seen !== 1'b0) begin
      $display("FAIL start_release: got pulse=%b expected 0", seen);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_cycle_gate();
    bit seen;
    led_state = 3'b010;
    btn_cycle_raw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cycle_select) seen = 1'b1;
    end
    if (seen !== 1'b0) begin
      $display("FAIL cycle_gated: got pulse=%b expected 0", seen);
      n_fail++;
    end
    n_checks++;
    btn_cycle_raw = 1'b0;
    ticks(8);
    led_state = 3'b000;
    btn_cycle_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cycle_select !== (i == 6)) begin
        $display("FAIL cycle_idle[%0d]: got %b expected %b", i, cycle_select, (i == 6));
        n_fail++;
      end
      n_checks++;
    end
    btn_cycle_raw = 1'b0;
    ticks(8);
  endtask

  task automatic test_back_to_back();
    btn_start_raw = 1'b1;
    btn_cycle_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if ({start_stop, cycle_select} !== ((i == 6) ? 2'b11 : 2'b00)) begin
        $display("FAIL both_buttons[%0d]: got %b expected %b", i, {start_stop, cycle_select},
                 ((i == 6) ? 2'b11 : 2'b00));
        n_fail++;
      end
      n_checks++;
    end
    btn_start_raw = 1'b0;
    btn_cycle_raw = 1'b0;
    ticks(8);
  endtask

  task automatic test_display();
    logic [3:0] vin  [5];
    logic [6:0] vexp [5];
    logic [1:0] cin  [4];
    logic [2:0] cexp [4];
    vin[0] = 4'hA; vexp[0] = 7'h77;
    vin[1] = 4'hB; vexp[1] = 7'h7C;
    vin[2] = 4'h0; vexp[2] = 7'h3F;
    vin[3] = 4'hF; vexp[3] = 7'h71;
    vin[4] = 4'h8; vexp[4] = 7'h7F;
    cin[0] = 2'b11; cexp[0] = 3'b000;
    cin[1] = 2'b00; cexp[1] = 3'b001;
    cin[2] = 2'b01; cexp[2] = 3'b010;
    cin[3] = 2'b10; cexp[3] = 3'b100;

    timer_display = 4'h5; led_state = 3'b011; led_cycle = 2'b10; door_lock = 1'b1;
    #1;
    if (seg_timer !== 7'h3F) begin
      $display("FAIL display_latency: got %h expected 3f", seg_timer);
      n_fail++;
    end
    n_checks++;
    tick();
    if ({seg_timer, seg_state, cycle_leds, lock_led} !== {7'h6D, 7'h4F, 3'b100, 1'b1}) begin
      $display("FAIL display_main: got %h %h %b %b expected 6d 4f 100 1",
               seg_timer, seg_state, cycle_leds, lock_led);
      n_fail++;
    end
    n_checks++;
    door_lock = 1'b0;
    for (int i = 0; i < 5; i++) begin
      timer_display = vin[i];
      tick();
      if (seg_timer !== vexp[i]) begin
        $display("FAIL hex_%h: got %h expected %h", vin[i], seg_timer, vexp[i]);
        n_fail++;
      end
      n_checks++;
    end
    if (lock_led !== 1'b0) begin
      $display("FAIL lock_off: got %b expected 0", lock_led);
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      led_cycle = cin[i];
      tick();
      if (cycle_leds !== cexp[i]) begin
        $display("FAIL cycle_leds_%b: got %b expected %b", cin[i], cycle_leds, cexp[i]);
        n_fail++;
      end
      n_checks++;
    end
    led_state = 3'b000; led_cycle = 2'b00; timer_display = 4'h0;
    tick();
  endtask

  task automatic test_beep_oneshot();
    logic exp;
    led_state = 3'b111;
    buzzer = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp = (i <= 12) && (((i - 1) % 4) < 2);
      if (buzzer_out !== exp) begin
        $display("FAIL oneshot[%0d]: got %b expected %b", i, buzzer_out, exp);
        n_fail++;
      end
      n_checks++;
    end
    buzzer = 1'b0;
    tick();
    if (buzzer_out !== 1'b0) begin
      $display("FAIL oneshot_off: got %b expected 0", buzzer_out);
      n_fail++;
    end
    n_checks++;
    ticks(2);
  endtask

  task automatic test_beep_repeat();
    logic exp;
    led_state = 3'b110;
    buzzer = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      exp = (((i - 1) % 4) < 2);
      if (buzzer_out !== exp) begin
        $display("FAIL repeat[%0d]: got %b expected %b", i, buzzer_out, exp);
        n_fail++;
      end
      n_checks++;
      if (i == 6) led_state = 3'b111;
    end
    buzzer = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (buzzer_out !== 1'b0) begin
        $display("FAIL repeat_stop[%0d]: got %b expected 0", i, buzzer_out);
        n_fail++;
      end
      n_checks++;
    end
    led_state = 3'b000;
    ticks(2);
  endtask

  task automatic test_reset_mid();
    btn_start_raw = 1'b1;
    ticks(8);
    door_sw_raw = 1'b1;
    ticks(3);
    reset = 1'b1;
    ticks(2);
    if ({start_stop, cycle_select, door_open, seg_timer, seg_state, cycle_leds, lock_led, buzzer_out}
        !== 22'h0) begin
      $display("FAIL reset_mid_outputs: got %b%b%b %h %h %b %b %b expected all 0",
               start_stop, cycle_select, door_open, seg_timer, seg_state, cycle_leds, lock_led, buzzer_out);
      n_fail++;
    end
    n_checks++;
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if ({door_open, start_stop} !== {(i >= 6), (i == 6)}) begin
        $display("FAIL after_reset[%0d]: got door=%b start=%b expected door=%b start=%b",
                 i, door_open, start_stop, (i >= 6), (i == 6));
        n_fail++;
      end
      n_checks++;
    end
    btn_start_raw = 1'b0;
    door_sw_raw = 1'b0;
    ticks(8);
  endtask

  initial begin
    test_reset();
    test_door();
    test_start();
    test_cycle_gate();
    test_back_to_back();
    test_display();
    test_beep_oneshot();
    test_beep_repeat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
